// File: rtl/bel_fft_seq_ctrl.sv
// Configuration sequencer for bel_fft_core: writes size/src/dst/factors/control
// over Avalon-MM, then waits for completion on the interrupt or by status polling.
module bel_fft_seq_ctrl #(
    parameter int unsigned DWIDTH    = 32,
    parameter int unsigned AWIDTH    = 4,
    parameter int unsigned BCNT      = DWIDTH / 8,
    parameter int unsigned NFACT     = 5,
    parameter int unsigned A_CTRL    = 0,
    parameter int unsigned A_STAT    = 1,
    parameter int unsigned A_SIZE    = 2,
    parameter int unsigned A_SRC     = 3,
    parameter int unsigned A_DST     = 4,
    parameter int unsigned A_FACT0   = 5,
    parameter int unsigned POLL_MODE = 0,
    parameter int unsigned POLL_GAP  = 4,
    parameter int unsigned TIMEOUT   = 65535
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_inverse,
    input  logic [DWIDTH-1:0]       i_fft_size,
    input  logic [DWIDTH-1:0]       i_src_addr,
    input  logic [DWIDTH-1:0]       i_dst_addr,
    input  logic [NFACT*DWIDTH-1:0] i_factors,
    input  logic                    i_int,
    output logic [AWIDTH-1:0]       o_s_address,
    output logic [DWIDTH-1:0]       o_s_writedata,
    output logic                    o_s_write,
    output logic                    o_s_read,
    output logic [BCNT-1:0]         o_s_byteenable,
    input  logic [DWIDTH-1:0]       i_s_readdata,
    input  logic                    i_s_waitrequest,
    input  logic                    i_s_readdatavalid,
    output logic                    o_busy,
    output logic                    o_done,
    output logic                    o_error,
    output logic [DWIDTH-1:0]       o_status
);

    localparam int unsigned NWR      = NFACT + 4;
    localparam int unsigned IDX_W    = $clog2(NWR);
    localparam int unsigned FW       = NFACT * DWIDTH;
    localparam int unsigned CNT_W    = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W    = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;
    localparam int unsigned GAP_LAST = (POLL_GAP == 0) ? 0 : POLL_GAP - 1;
    localparam bit          TO_EN    = (TIMEOUT != 0);

    typedef enum logic [2:0] {
        S_IDLE, S_WR, S_WAIT, S_RD, S_RDV, S_GAP, S_DONE, S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [GAP_W-1:0]    gap_q, gap_d;
    logic                inv_q, inv_d;
    logic [DWIDTH-1:0]   size_q, size_d, src_q, src_d, dst_q, dst_d;
    logic [FW-1:0]       fact_q, fact_d;
    logic [AWIDTH-1:0]   addr_q, addr_d;
    logic [DWIDTH-1:0]   wdata_q, wdata_d;
    logic                write_q, write_d, read_q, read_d;
    logic [BCNT-1:0]     be_q, be_d;
    logic                busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [DWIDTH-1:0]   status_q, status_d;
    logic                timed_out;
    logic [CNT_W-1:0]    cnt_inc;

    // Register address for write slot idx.
    function automatic logic [AWIDTH-1:0] wr_addr(input logic [IDX_W-1:0] idx);
        logic [AWIDTH-1:0] a;
        if (idx == IDX_W'(0))            a = AWIDTH'(A_SIZE);
        else if (idx == IDX_W'(1))       a = AWIDTH'(A_SRC);
        else if (idx == IDX_W'(2))       a = AWIDTH'(A_DST);
        else if (idx == IDX_W'(NWR - 1)) a = AWIDTH'(A_CTRL);
        else                             a = AWIDTH'(A_FACT0 + 32'(idx) - 32'd3);
        return a;
    endfunction

    // Write data for slot idx; control word carries start, int-enable and inverse.
    function automatic logic [DWIDTH-1:0] wr_data(
        input logic [IDX_W-1:0]  idx,
        input logic              inv,
        input logic [DWIDTH-1:0] size,
        input logic [DWIDTH-1:0] src,
        input logic [DWIDTH-1:0] dst,
        input logic [FW-1:0]     fact
    );
        logic [DWIDTH-1:0] d;
        d = '0;
        if (idx == IDX_W'(0))      d = size;
        else if (idx == IDX_W'(1)) d = src;
        else if (idx == IDX_W'(2)) d = dst;
        else if (idx == IDX_W'(NWR - 1)) begin
            d[0]  = 1'b1;
            d[8]  = (POLL_MODE == 0);
            d[16] = inv;
        end else begin
            d = fact[(32'(idx) - 32'd3) * DWIDTH +: DWIDTH];
        end
        return d;
    endfunction

    assign timed_out = TO_EN && (cnt_q == CNT_W'(TIMEOUT));
    assign cnt_inc   = timed_out ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        cnt_d    = cnt_q;
        gap_d    = gap_q;
        inv_d    = inv_q;
        size_d   = size_q;
        src_d    = src_q;
        dst_d    = dst_q;
        fact_d   = fact_q;
        busy_d   = busy_q;
        error_d  = error_q;
        status_d = status_q;
        done_d   = 1'b0;
        write_d  = 1'b0;
        read_d   = 1'b0;
        addr_d   = '0;
        wdata_d  = '0;
        be_d     = '0;

        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    state_d  = S_WR;
                    idx_d    = '0;
                    inv_d    = i_inverse;
                    size_d   = i_fft_size;
                    src_d    = i_src_addr;
                    dst_d    = i_dst_addr;
                    fact_d   = i_factors;
                    error_d  = 1'b0;
                    status_d = '0;
                    busy_d   = 1'b1;
                    write_d  = 1'b1;
                end
            end
            S_WR: begin
                write_d = 1'b1;
                if (!i_s_waitrequest) begin
                    if (idx_q == IDX_W'(NWR - 1)) begin
                        write_d = 1'b0;
                        cnt_d   = '0;
                        if (POLL_MODE != 0) begin
                            state_d = S_RD;
                            read_d  = 1'b1;
                        end else begin
                            state_d = S_WAIT;
                        end
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                if (i_int) begin
                    state_d = S_DONE;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                end else if (timed_out) begin
                    state_d = S_ERR;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end
            end
            S_RD: begin
                cnt_d  = cnt_inc;
                read_d = i_s_waitrequest;
                if (!i_s_waitrequest) state_d = S_RDV;
            end
            S_RDV: begin
                cnt_d = cnt_inc;
                if (i_s_readdatavalid) begin
                    status_d = i_s_readdata;
                    if (i_s_readdata[0]) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                    end else if (timed_out) begin
                        state_d = S_ERR;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                        busy_d  = 1'b0;
                    end else if (POLL_GAP == 0) begin
                        state_d = S_RD;
                        read_d  = 1'b1;
                    end else begin
                        state_d = S_GAP;
                        gap_d   = '0;
                    end
                end
            end
            S_GAP: begin
                cnt_d = cnt_inc;
                if (timed_out) begin
                    state_d = S_ERR;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                    busy_d  = 1'b0;
                end else if (gap_q == GAP_W'(GAP_LAST)) begin
                    state_d = S_RD;
                    read_d  = 1'b1;
                end else begin
                    gap_d = gap_q + GAP_W'(1);
                end
            end
            S_DONE, S_ERR: state_d = S_IDLE;
            default:       state_d = S_IDLE;
        endcase

        // Bus fields follow the next-cycle strobe so they are stable while stalled.
        if (write_d) begin
            addr_d  = wr_addr(idx_d);
            wdata_d = wr_data(idx_d, inv_d, size_d, src_d, dst_d, fact_d);
        end else if (read_d) begin
            addr_d = AWIDTH'(A_STAT);
        end
        if (write_d || read_d) be_d = '1;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            cnt_q    <= '0;
            gap_q    <= '0;
            inv_q    <= 1'b0;
            size_q   <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            fact_q   <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            write_q  <= 1'b0;
            read_q   <= 1'b0;
            be_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            error_q  <= 1'b0;
            status_q <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            cnt_q    <= cnt_d;
            gap_q    <= gap_d;
            inv_q    <= inv_d;
            size_q   <= size_d;
            src_q    <= src_d;
            dst_q    <= dst_d;
            fact_q   <= fact_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            write_q  <= write_d;
            read_q   <= read_d;
            be_q     <= be_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            error_q  <= error_d;
            status_q <= status_d;
        end
    end

    assign o_s_address    = addr_q;
    assign o_s_writedata  = wdata_q;
    assign o_s_write      = write_q;
    assign o_s_read       = read_q;
    assign o_s_byteenable = be_q;
    assign o_busy         = busy_q;
    assign o_done         = done_q;
    assign o_error        = error_q;
    assign o_status       = status_q;

endmodule

// File: tb/tb_bel_fft_seq_ctrl.sv
// Bench for bel_fft_seq_ctrl: interrupt, stalled, polled, timeout, reset and
// held-start scenarios, checked against an expected-write scoreboard.
module tb_bel_fft_seq_ctrl;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 4;
    localparam int unsigned BC = 4;
    localparam int unsigned NF = 5;
    localparam int unsigned NW = NF + 4;
    localparam int          RD_LAT = 2;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              start [3];
    logic              inverse;
    logic [DW-1:0]     size, src, dst;
    logic [NF*DW-1:0]  facts;
    logic              irq;
    logic [DW-1:0]     rdata;
    logic              wreq, rdv;

    logic [AW-1:0]     s_addr  [3];
    logic [DW-1:0]     s_wdata [3];
    logic              s_wr    [3];
    logic              s_rd    [3];
    logic [BC-1:0]     s_be    [3];
    logic              busy    [3];
    logic              done    [3];
    logic              err     [3];
    logic [DW-1:0]     status  [3];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int sel = 0;
    int stall_n = 0;
    bit hold = 1'b0;

    // Owned by the negedge slave/monitor process
    int stall_cnt = 0, pend = 0, rd_served = 0;
    int wr_cycles = 0, unstable = 0, both_cnt = 0, done_cnt = 0, done_cyc = 0;
    bit pstall = 1'b0;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    wr_t           obs_q [$];
    int            obs_cyc [$];
    logic [AW-1:0] rd_addr [$];
    int            rd_cyc [$];

    wr_t exp_q [$];

    always #5 clk = ~clk;

    bel_fft_seq_ctrl #(.NFACT(NF)) u_irq (
        .i_clk(clk), .i_rst(rst), .i_start(start[0]), .i_inverse(inverse),
        .i_fft_size(size), .i_src_addr(src), .i_dst_addr(dst), .i_factors(facts),
        .i_int(irq), .o_s_address(s_addr[0]), .o_s_writedata(s_wdata[0]),
        .o_s_write(s_wr[0]), .o_s_read(s_rd[0]), .o_s_byteenable(s_be[0]),
        .i_s_readdata(rdata), .i_s_waitrequest(wreq), .i_s_readdatavalid(rdv),
        .o_busy(busy[0]), .o_done(done[0]), .o_error(err[0]), .o_status(status[0])
    );

    bel_fft_seq_ctrl #(.NFACT(NF), .POLL_MODE(1), .POLL_GAP(2)) u_poll (
        .i_clk(clk), .i_rst(rst), .i_start(start[1]), .i_inverse(inverse),
        .i_fft_size(size), .i_src_addr(src), .i_dst_addr(dst), .i_factors(facts),
        .i_int(irq), .o_s_address(s_addr[1]), .o_s_writedata(s_wdata[1]),
        .o_s_write(s_wr[1]), .o_s_read(s_rd[1]), .o_s_byteenable(s_be[1]),
        .i_s_readdata(rdata), .i_s_waitrequest(wreq), .i_s_readdatavalid(rdv),
        .o_busy(busy[1]), .o_done(done[1]), .o_error(err[1]), .o_status(status[1])
    );

    bel_fft_seq_ctrl #(.NFACT(NF), .TIMEOUT(10)) u_to (
        .i_clk(clk), .i_rst(rst), .i_start(start[2]), .i_inverse(inverse),
        .i_fft_size(size), .i_src_addr(src), .i_dst_addr(dst), .i_factors(facts),
        .i_int(irq), .o_s_address(s_addr[2]), .o_s_writedata(s_wdata[2]),
        .o_s_write(s_wr[2]), .o_s_read(s_rd[2]), .o_s_byteenable(s_be[2]),
        .i_s_readdata(rdata), .i_s_waitrequest(wreq), .i_s_readdatavalid(rdv),
        .o_busy(busy[2]), .o_done(done[2]), .o_error(err[2]), .o_status(status[2])
    );

    // Slave model and bus monitor for the selected instance; drives for the next posedge.
    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            pend = 0; stall_cnt = 0; wreq = 1'b0; rdv = 1'b0; pstall = 1'b0;
        end else begin
            rdv = 1'b0;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    rdv = 1'b1;
                    rdata = (rd_served >= 2) ? 32'h0000_0001 : 32'h0000_0000;
                    rd_served++;
                end
            end
            if (s_wr[sel] || s_rd[sel]) begin
                if (hold) wreq = 1'b1;
                else if (stall_cnt < stall_n) begin wreq = 1'b1; stall_cnt++; end
                else begin wreq = 1'b0; stall_cnt = 0; end
            end else begin
                wreq = 1'b0; stall_cnt = 0;
            end
            if (s_wr[sel] && s_rd[sel]) both_cnt++;
            if (s_wr[sel]) wr_cycles++;
            if (pstall && (!s_wr[sel] || s_addr[sel] != pa || s_wdata[sel] != pd)) unstable++;
            pstall = s_wr[sel] && wreq;
            pa = s_addr[sel];
            pd = s_wdata[sel];
            if (s_wr[sel] && !wreq) begin
                obs_q.push_back('{a: s_addr[sel], d: s_wdata[sel]});
                obs_cyc.push_back(cyc);
            end
            if (s_rd[sel] && !wreq) begin
                rd_addr.push_back(s_addr[sel]);
                rd_cyc.push_back(cyc);
                pend = RD_LAT;
            end
            if (done[sel]) begin done_cnt++; done_cyc = cyc; end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic push_exp(input logic inv, input bit poll);
        logic [DW-1:0] ctrl;
        exp_q.push_back('{a: 4'd2, d: size});
        exp_q.push_back('{a: 4'd3, d: src});
        exp_q.push_back('{a: 4'd4, d: dst});
        for (int k = 0; k < NF; k++) exp_q.push_back('{a: 4'(5 + k), d: facts[k*DW +: DW]});
        ctrl = 32'h1;
        if (!poll) ctrl = ctrl | 32'h100;
        if (inv)   ctrl = ctrl | 32'h1_0000;
        exp_q.push_back('{a: 4'd0, d: ctrl});
    endtask

    task automatic pulse_start(input int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
    endtask

    task automatic test_reset;
        #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({s_wr[i], s_rd[i], s_addr[i], s_wdata[i], s_be[i], busy[i], done[i], err[i], status[i]} !== '0) begin
                errors++;
                $display("FAIL reset_outputs[%0d]: wr=%b rd=%b addr=%0d busy=%b done=%b err=%b status=%h, want all 0",
                         i, s_wr[i], s_rd[i], s_addr[i], busy[i], done[i], err[i], status[i]);
            end
        end
        @(posedge clk); #1 rst = 1'b0;
    endtask

    task automatic test_irq;
        int n, optr, d0;
        wr_t e, o;
        sel = 0;
        size = 32'd256; src = 32'h400; dst = 32'h800; inverse = 1'b1;
        push_exp(1'b1, 1'b0);
        optr = obs_q.size();
        d0 = done_cnt;
        pulse_start(0);
        irq = 1'b1;
        @(negedge clk);
        checks++;
        if (s_wr[0] !== 1'b1 || busy[0] !== 1'b1 || s_be[0] !== 4'hF || s_addr[0] !== 4'd2) begin
            errors++;
            $display("FAIL irq_first_write: wr=%b busy=%b be=%h addr=%0d, want 1 1 f 2", s_wr[0], busy[0], s_be[0], s_addr[0]);
        end
        n = 0;
        while (obs_q.size() < optr + NW && n < 100) begin
            @(posedge clk); #1 n++;
            if (n == 3) irq = 1'b0;
        end
        irq = 1'b0;
        checks++;
        if (obs_q.size() < optr + NW) begin
            errors++;
            $display("FAIL irq_write_count: got %0d, want %0d", obs_q.size() - optr, NW);
        end
        for (int i = 0; i < NW; i++) begin
            e = exp_q.pop_front();
            o = obs_q[optr + i];
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL irq_write[%0d]: got a=%0d d=%h, want a=%0d d=%h", i, o.a, o.d, e.a, e.d);
            end
        end
        o = obs_q[optr + NW - 1];
        checks++;
        if (o.d !== 32'h0001_0101) begin
            errors++;
            $display("FAIL irq_ctrl_word: got %h, want 00010101", o.d);
        end
        checks++;
        if (obs_cyc[optr + NW - 1] - obs_cyc[optr] != NW - 1) begin
            errors++;
            $display("FAIL irq_back_to_back: span %0d cycles, want %0d", obs_cyc[optr + NW - 1] - obs_cyc[optr], NW - 1);
        end
        checks++;
        if (done_cnt != d0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL irq_ignored_in_wr: done_cnt delta=%0d busy=%b, want 0 1", done_cnt - d0, busy[0]);
        end
        repeat (20) @(posedge clk);
        #1 irq = 1'b1;
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b1) begin
            errors++;
            $display("FAIL irq_done_early: done=%b busy=%b, want 0 1", done[0], busy[0]);
        end
        @(posedge clk); #1 irq = 1'b0;
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b1 || busy[0] !== 1'b0 || err[0] !== 1'b0) begin
            errors++;
            $display("FAIL irq_done_pulse: done=%b busy=%b err=%b, want 1 0 0", done[0], busy[0], err[0]);
        end
        @(negedge clk);
        checks++;
        if (done[0] !== 1'b0 || busy[0] !== 1'b0 || s_be[0] !== 4'h0) begin
            errors++;
            $display("FAIL irq_done_one_cycle: done=%b busy=%b be=%h, want 0 0 0", done[0], busy[0], s_be[0]);
        end
    endtask

    task automatic test_stall;
        int n, optr, w0, u0, d0;
        wr_t e, o;
        sel = 0; stall_n = 3;
        size = 32'd1024; src = 32'h1234_5670; dst = 32'hABCD_0000; inverse = 1'b0;
        push_exp(1'b0, 1'b0);
        optr = obs_q.size(); w0 = wr_cycles; u0 = unstable; d0 = done_cnt;
        pulse_start(0);
        n = 0;
        while (obs_q.size() < optr + NW && n < 200) begin @(posedge clk); #1 n++; end
        checks++;
        if (obs_q.size() < optr + NW) begin
            errors++;
            $display("FAIL stall_write_count: got %0d, want %0d", obs_q.size() - optr, NW);
        end
        for (int i = 0; i < NW; i++) begin
            e = exp_q.pop_front();
            o = obs_q[optr + i];
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL stall_write[%0d]: got a=%0d d=%h, want a=%0d d=%h", i, o.a, o.d, e.a, e.d);
            end
        end
        checks++;
        if (wr_cycles - w0 != 4 * NW) begin
            errors++;
            $display("FAIL stall_write_cycles: got %0d, want %0d", wr_cycles - w0, 4 * NW);
        end
        checks++;
        if (unstable != u0) begin
            errors++;
            $display("FAIL stall_stable: %0d unstable stalled cycles, want 0", unstable - u0);
        end
        stall_n = 0;
        irq = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 50) begin @(posedge clk); #1 n++; end
        irq = 1'b0;
        checks++;
        if (done_cnt == d0) begin errors++; $display("FAIL stall_done: no done seen, want one"); end
    endtask

    task automatic test_poll;
        int n, optr, r0, d0;
        wr_t e, o;
        sel = 1;
        size = 32'd64; src = 32'h2000; dst = 32'h3000; inverse = 1'b0;
        push_exp(1'b0, 1'b1);
        optr = obs_q.size(); r0 = rd_addr.size(); d0 = done_cnt;
        pulse_start(1);
        n = 0;
        while (done_cnt == d0 && n < 300) begin @(posedge clk); #1 n++; end
        checks++;
        if (done_cnt == d0) begin errors++; $display("FAIL poll_done: no done seen, want one"); end
        for (int i = 0; i < NW; i++) begin
            e = exp_q.pop_front();
            o = obs_q[optr + i];
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL poll_write[%0d]: got a=%0d d=%h, want a=%0d d=%h", i, o.a, o.d, e.a, e.d);
            end
        end
        checks++;
        if (rd_addr.size() - r0 != 3) begin
            errors++;
            $display("FAIL poll_read_count: got %0d, want 3", rd_addr.size() - r0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (rd_addr[r0 + i] !== 4'd1) begin
                    errors++;
                    $display("FAIL poll_read_addr[%0d]: got %0d, want 1", i, rd_addr[r0 + i]);
                end
            end
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (rd_cyc[r0 + i] - rd_cyc[r0 + i - 1] != 5) begin
                    errors++;
                    $display("FAIL poll_read_spacing[%0d]: got %0d, want 5", i, rd_cyc[r0 + i] - rd_cyc[r0 + i - 1]);
                end
            end
        end
        checks++;
        if (status[1] !== 32'h1 || err[1] !== 1'b0) begin
            errors++;
            $display("FAIL poll_status: status=%h err=%b, want 00000001 0", status[1], err[1]);
        end
    endtask

    task automatic test_timeout;
        int n, optr, d0;
        wr_t e, o;
        sel = 2;
        size = 32'd512; src = 32'h5000; dst = 32'h6000; inverse = 1'b0;
        push_exp(1'b0, 1'b0);
        optr = obs_q.size();
        pulse_start(2);
        n = 0;
        while (obs_q.size() < optr + NW && n < 100) begin @(posedge clk); #1 n++; end
        for (int i = 0; i < NW; i++) begin
            e = exp_q.pop_front();
            o = obs_q[optr + i];
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL to_write[%0d]: got a=%0d d=%h, want a=%0d d=%h", i, o.a, o.d, e.a, e.d);
            end
        end
        repeat (10) @(posedge clk);
        @(negedge clk);
        checks++;
        if (done[2] !== 1'b0 || err[2] !== 1'b0 || busy[2] !== 1'b1) begin
            errors++;
            $display("FAIL to_early: done=%b err=%b busy=%b, want 0 0 1", done[2], err[2], busy[2]);
        end
        @(negedge clk);
        checks++;
        if (done[2] !== 1'b1 || err[2] !== 1'b1 || busy[2] !== 1'b0) begin
            errors++;
            $display("FAIL to_expire: done=%b err=%b busy=%b, want 1 1 0", done[2], err[2], busy[2]);
        end
        @(negedge clk);
        checks++;
        if (done[2] !== 1'b0 || err[2] !== 1'b1) begin
            errors++;
            $display("FAIL to_sticky: done=%b err=%b, want 0 1", done[2], err[2]);
        end
        d0 = done_cnt;
        pulse_start(2);
        @(negedge clk);
        checks++;
        if (err[2] !== 1'b0 || busy[2] !== 1'b1 || s_wr[2] !== 1'b1) begin
            errors++;
            $display("FAIL to_restart_clear: err=%b busy=%b wr=%b, want 0 1 1", err[2], busy[2], s_wr[2]);
        end
        irq = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 50) begin @(posedge clk); #1 n++; end
        irq = 1'b0;
        checks++;
        if (done_cnt == d0 || err[2] !== 1'b0) begin
            errors++;
            $display("FAIL to_second_run: done_seen=%0d err=%b, want 1 0", done_cnt - d0, err[2]);
        end
    endtask

    task automatic test_reset_mid;
        int n, optr, d0;
        wr_t e, o;
        sel = 0; stall_n = 0;
        size = 32'd128; src = 32'h7000; dst = 32'h8000; inverse = 1'b1;
        optr = obs_q.size();
        pulse_start(0);
        n = 0;
        while (obs_q.size() < optr + 4 && n < 50) begin @(posedge clk); #1 n++; end
        hold = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (s_wr[0] !== 1'b1 || s_addr[0] !== 4'd6 || s_wdata[0] !== facts[DW +: DW]) begin
            errors++;
            $display("FAIL rst_stalled_idx4: wr=%b addr=%0d data=%h, want 1 6 %h", s_wr[0], s_addr[0], s_wdata[0], facts[DW +: DW]);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({s_wr[0], s_rd[0], s_addr[0], s_wdata[0], s_be[0], busy[0], done[0], err[0], status[0]} !== '0) begin
            errors++;
            $display("FAIL rst_async_clear: wr=%b addr=%0d data=%h be=%h busy=%b, want all 0",
                     s_wr[0], s_addr[0], s_wdata[0], s_be[0], busy[0]);
        end
        @(posedge clk); #1 rst = 1'b0; hold = 1'b0;
        push_exp(1'b1, 1'b0);
        optr = obs_q.size(); d0 = done_cnt;
        pulse_start(0);
        n = 0;
        while (obs_q.size() < optr + NW && n < 100) begin @(posedge clk); #1 n++; end
        for (int i = 0; i < NW; i++) begin
            e = exp_q.pop_front();
            o = obs_q[optr + i];
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL rst_restart_write[%0d]: got a=%0d d=%h, want a=%0d d=%h", i, o.a, o.d, e.a, e.d);
            end
        end
        irq = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 50) begin @(posedge clk); #1 n++; end
        irq = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n, optr, d0, dc;
        wr_t e, o;
        sel = 0;
        size = 32'd2048; src = 32'h9000; dst = 32'hA000; inverse = 1'b0;
        push_exp(1'b0, 1'b0);
        push_exp(1'b0, 1'b0);
        optr = obs_q.size(); d0 = done_cnt;
        @(posedge clk); #1 start[0] = 1'b1;
        n = 0;
        while (obs_q.size() < optr + NW && n < 100) begin @(posedge clk); #1 n++; end
        irq = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 50) begin @(posedge clk); #1 n++; end
        irq = 1'b0;
        dc = done_cyc;
        n = 0;
        while (obs_q.size() < optr + 2 * NW && n < 100) begin @(posedge clk); #1 n++; end
        start[0] = 1'b0;
        checks++;
        if (obs_q.size() != optr + 2 * NW) begin
            errors++;
            $display("FAIL b2b_write_count: got %0d, want %0d", obs_q.size() - optr, 2 * NW);
        end
        for (int i = 0; i < 2 * NW; i++) begin
            e = exp_q.pop_front();
            o = obs_q[optr + i];
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL b2b_write[%0d]: got a=%0d d=%h, want a=%0d d=%h", i, o.a, o.d, e.a, e.d);
            end
        end
        checks++;
        if (obs_cyc[optr + NW] - dc != 2) begin
            errors++;
            $display("FAIL b2b_restart_gap: first write %0d cycles after done, want 2", obs_cyc[optr + NW] - dc);
        end
        d0 = done_cnt;
        irq = 1'b1;
        n = 0;
        while (done_cnt == d0 && n < 50) begin @(posedge clk); #1 n++; end
        irq = 1'b0;
        repeat (2) @(posedge clk);
        checks++;
        if (both_cnt != 0 || busy[0] !== 1'b0) begin
            errors++;
            $display("FAIL bus_rules: read+write overlap cycles=%0d busy=%b, want 0 0", both_cnt, busy[0]);
        end
    endtask

    initial begin
        rst = 1'b1; irq = 1'b0; inverse = 1'b0;
        start[0] = 1'b0; start[1] = 1'b0; start[2] = 1'b0;
        size = '0; src = '0; dst = '0;
        for (int k = 0; k < NF; k++) facts[k*DW +: DW] = 32'hF00D_0000 + 32'(k * 17 + 3);
        repeat (3) @(posedge clk);
        test_reset;
        test_irq;
        test_stall;
        test_poll;
        test_timeout;
        test_reset_mid;
        test_back_to_back;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bel_fft_seq_ctrl.md
Name: bel_fft_seq_ctrl

Overview:
Parametrised configuration sequencer for bel_fft_core. It drives the core's Avalon-MM slave port and performs a fixed sequence:
- writes the size, source, destination and NFACT factor registers, then the control register;
- waits for completion either on i_int (interrupt mode) or by polling the status register (poll mode).

It fully honours waitrequest/readdatavalid, adds a completion timeout, and sits between the top-level FFT master and bel_fft_core.

Parameters:
DWIDTH, 32, data word width
AWIDTH, 4, slave address width
BCNT, DWIDTH/8, byteenable width
NFACT, 5, number of factor registers written (1..8)
A_CTRL, 0, control register address
A_STAT, 1, status register address
A_SIZE, 2, size register address
A_SRC, 3, source register address
A_DST, 4, destination register address
A_FACT0, 5, first factor register; factor k is written at A_FACT0+k
POLL_MODE, 0, 0 = wait for i_int, 1 = poll A_STAT bit0
POLL_GAP, 4, idle cycles between status reads (0 allowed)
TIMEOUT, 65535, wait-phase cycle limit; 0 disables the timeout

Ports:
i_clk  in  1  clock
i_rst  in  1  reset, asynchronous, active-high
i_start  in  1  start request, sampled in IDLE only
i_inverse  in  1  inverse-FFT select
i_fft_size  in  DWIDTH  FFT size
i_src_addr  in  DWIDTH  source buffer address
i_dst_addr  in  DWIDTH  destination buffer address
i_factors  in  NFACT*DWIDTH  factor k occupies bits [k*DWIDTH +: DWIDTH]
i_int  in  1  core completion interrupt
o_s_address  out  AWIDTH  slave address
o_s_writedata  out  DWIDTH  write data
o_s_write  out  1  write strobe
o_s_read  out  1  read strobe
o_s_byteenable  out  BCNT  all ones during a transaction, else 0
i_s_readdata  in  DWIDTH  read data
i_s_waitrequest  in  1  slave stall
i_s_readdatavalid  in  1  read data valid
o_busy  out  1  high from the cycle after start accept until DONE/ERR exit
o_done  out  1  one-cycle completion pulse
o_error  out  1  sticky timeout flag, cleared on next accepted start
o_status  out  DWIDTH  last status word read (poll mode); 0 in interrupt mode

Behaviour:
Reset:
- All outputs are 0, state = IDLE, index and counters = 0.
- Reset mid-operation aborts immediately; no transaction completion is owed.

Start and snapshot:
- IDLE + i_start: latch i_inverse, i_fft_size, i_src_addr, i_dst_addr, i_factors; clear o_error and o_status.
- Go to WR with idx = 0. o_s_write is high in the following cycle.

Write sequence (idx 0..NFACT+3):
- idx 0: A_SIZE / size; 1: A_SRC / src; 2: A_DST / dst.
- idx 3..NFACT+2: A_FACT0+(idx-3) / factor[idx-3].
- idx NFACT+3: A_CTRL / ctrl.
- ctrl = bit0 start = 1, bit8 int-enable = ~POLL_MODE, bit16 = inverse; all other bits 0.

Write handshake:
- Address, data, write and byteenable stay stable while i_s_waitrequest = 1.
- A transfer completes on a rising edge with write = 1 and waitrequest = 0.
- Next write is presented back-to-back the following cycle, so with no stalls the sequence takes NFACT+4 consecutive cycles.
- After the control write completes, go to WAIT.

WAIT, interrupt mode:
- i_int = 1 → DONE.
- i_int asserted during WR is ignored; only WAIT samples it.

WAIT, poll mode:
- RD: o_s_read = 1 at A_STAT, held until waitrequest = 0.
- RDV: wait for i_s_readdatavalid, then o_status <= i_s_readdata.
- If bit0 = 1 → DONE; else idle POLL_GAP cycles and return to RD.

Timeout:
- The wait counter starts at 0 on WAIT entry and increments every cycle in WAIT/RD/RDV/gap.
- When it reaches TIMEOUT (TIMEOUT != 0), go to ERR. If a read is outstanding, finish its handshake and data phase first.
- Completion seen in the same cycle the counter reaches TIMEOUT wins → DONE.

Exit states:
- DONE: o_done = 1 for one cycle, then IDLE.
- ERR: o_done = 1 and o_error = 1 for one cycle, then IDLE; o_error stays high.

Other rules:
- o_busy deasserts in the cycle o_done is high.
- i_start outside IDLE is ignored; i_start in the o_done cycle is ignored, so the earliest restart is the next cycle.
- Read and write are never asserted together.

Test Plan:
- NFACT=5, interrupt mode, no stalls. Start with size=256, src=0x400, dst=0x800, inverse=1 → 9 back-to-back writes to addrs 2,3,4,5..9,0; ctrl=0x00010101. i_int 20 cycles later → o_done pulse the next cycle.
- waitrequest high 3 cycles on every write → each write held stable 4 cycles; order and data unchanged; 36 write cycles total.
- POLL_MODE=1, POLL_GAP=2; status reads return 0, 0, 1 with readdatavalid 2 cycles after accept → 3 reads to addr 1 separated by 2 idle cycles; ctrl=0x00000001 (inverse=0); o_status=1; done.
- TIMEOUT=10, i_int never asserted → o_error=1 and o_done pulse on the cycle after the counter reaches 10; next start clears o_error.
- i_rst pulsed during a stalled write (idx=4) → all outputs 0 asynchronously; a new start restarts at idx 0 (A_SIZE).
- i_start held high continuously → each run is accepted only from IDLE; second run's first write appears 2 cycles after the o_done pulse.
